// File: rtl/read_buffer.sv
// Ping-pong pixel read buffer: single-word Avalon-MM reads fill one bank while
// the filter datapath drains the other through a valid/ack handshake.
module read_buffer #(
  parameter int DEPTH     = 6,
  parameter int ADDR_STEP = 4,
  parameter int CNT_W     = 20
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [31:0]      start_address,
  input  logic [CNT_W-1:0] total_pixels,
  input  logic             master_waitrequest,
  input  logic             master_readdatavalid,
  input  logic [31:0]      master_readdata,
  output logic             master_read,
  output logic [31:0]      master_address,
  output logic [23:0]      pixel_out,
  output logic             pixel_valid,
  input  logic             pixel_ack,
  output logic             busy,
  output logic             done_read
);
  localparam int IDX_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STALL, FINISH} state_t;

  state_t           state;
  logic [23:0]      bank_mem [2][DEPTH];
  logic [1:0]       bank_full;
  logic [IDX_W-1:0] bank_cnt [2];
  logic             fill_sel;
  logic             drain_sel;
  logic [IDX_W-1:0] fill_idx;
  logic [IDX_W-1:0] drain_idx;
  logic [IDX_W-1:0] burst_n;
  logic [IDX_W-1:0] issued;
  logic [IDX_W-1:0] outstanding;
  logic [CNT_W-1:0] remaining;

  logic             accept;
  logic             resp_ok;
  logic             drain_take;
  logic             drain_last;
  logic             mark_full;
  logic [1:0]       full_next;
  logic [CNT_W-1:0] rem_src;
  logic [IDX_W-1:0] next_burst;

  // The pixel word's top byte carries no information.
  logic unused_hi;
  assign unused_hi = ^master_readdata[31:24];

  assign pixel_valid = bank_full[drain_sel];
  assign pixel_out   = pixel_valid ? bank_mem[drain_sel][drain_idx] : '0;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    accept     = master_read && !master_waitrequest;
    resp_ok    = master_readdatavalid && (outstanding != '0);
    drain_take = pixel_valid && pixel_ack;
    drain_last = drain_take && ((drain_idx + IDX_W'(1)) == bank_cnt[drain_sel]);
    mark_full  = (state == WAIT) && (fill_idx == burst_n);
    // Bank status as it will be after this edge; the fill FSM decides on this view.
    full_next  = bank_full;
    if (drain_last) full_next[drain_sel] = 1'b0;
    if (mark_full)  full_next[fill_sel]  = 1'b1;
    rem_src    = (state == IDLE) ? total_pixels : remaining;
    next_burst = (rem_src >= CNT_W'(DEPTH)) ? IDX_W'(DEPTH) : rem_src[IDX_W-1:0];
  end

  // NOTE: pixel storage is deliberately not reset; bank_full gates every read of it.
  always_ff @(posedge clk) begin
    if (resp_ok) bank_mem[fill_sel][fill_idx] <= master_readdata[23:0];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= IDLE;
      master_read    <= 1'b0;
      master_address <= '0;
      busy           <= 1'b0;
      done_read      <= 1'b0;
      bank_full      <= '0;
      bank_cnt[0]    <= '0;
      bank_cnt[1]    <= '0;
      fill_sel       <= 1'b0;
      drain_sel      <= 1'b0;
      fill_idx       <= '0;
      drain_idx      <= '0;
      burst_n        <= '0;
      issued         <= '0;
      outstanding    <= '0;
      remaining      <= '0;
    end else begin
      done_read <= 1'b0;
      bank_full <= full_next;

      if (accept && !resp_ok)      outstanding <= outstanding + IDX_W'(1);
      else if (!accept && resp_ok) outstanding <= outstanding - IDX_W'(1);

      if (resp_ok) fill_idx <= fill_idx + IDX_W'(1);

      if (drain_last) begin
        drain_idx <= '0;
        drain_sel <= ~drain_sel;
      end else if (drain_take) begin
        drain_idx <= drain_idx + IDX_W'(1);
      end

      case (state)
        IDLE: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            busy           <= 1'b1;
            master_address <= start_address;
            remaining      <= total_pixels;
            fill_sel       <= 1'b0;
            drain_sel      <= 1'b0;
            issued         <= '0;
            if (total_pixels == '0) begin
              done_read <= 1'b1;
            end else begin
              burst_n     <= next_burst;
              master_read <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (accept) begin
            master_address <= master_address + 32'(ADDR_STEP);
            remaining      <= remaining - CNT_W'(1);
            issued         <= issued + IDX_W'(1);
            if ((issued + IDX_W'(1)) == burst_n) begin
              master_read <= 1'b0;
              state       <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mark_full) begin
            bank_cnt[fill_sel] <= burst_n;
            fill_idx           <= '0;
            issued             <= '0;
            if (remaining == '0) begin
              state <= FINISH;
            end else begin
              fill_sel <= ~fill_sel;
              if (!full_next[~fill_sel]) begin
                burst_n     <= next_burst;
                master_read <= 1'b1;
                state       <= ISSUE;
              end else begin
                state <= STALL;
              end
            end
          end
        end
        STALL: begin
          if (!full_next[fill_sel]) begin
            burst_n     <= next_burst;
            master_read <= 1'b1;
            state       <= ISSUE;
          end
        end
        FINISH: begin
          if (full_next == 2'b00) begin
            done_read <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_read_buffer.sv
// Bench for read_buffer: random-timing Avalon slave and consumer; expected
// address and pixel streams come straight from each frame's start/length.
`timescale 1ns/1ps
module tb_read_buffer;
  localparam int DEPTH     = 6;
  localparam int ADDR_STEP = 4;
  localparam int CNT_W     = 20;

  logic             clk = 1'b0;
  logic             n_rst = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      start_address = '0;
  logic [CNT_W-1:0] total_pixels = '0;
  logic             master_waitrequest = 1'b0;
  logic             master_readdatavalid = 1'b0;
  logic [31:0]      master_readdata = '0;
  logic             master_read;
  logic [31:0]      master_address;
  logic [23:0]      pixel_out;
  logic             pixel_valid;
  logic             pixel_ack = 1'b0;
  logic             busy;
  logic             done_read;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // slave knobs and observations
  int          wr_pct = 0, lat_min = 0, lat_max = 0;
  int          stall_req = -1, stall_len = 0, stall_cnt = 0;
  logic [31:0] stall_addr = '0;
  int          stable_err = 0;
  logic        prev_stalled = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] addr_log[$];
  int          acc_cycle[$];
  logic [31:0] resp_q[$];
  int          resp_due[$];
  int          last_due = 0;
  int          read_seen = 0;

  // consumer knobs and observations
  int          ack_pct = 100, ack_block_until = 0;
  logic [23:0] rx_q[$];
  int          ack_cycles[$];
  int          first_valid = -1, done_count = 0, done_cycle = -1, start_cycle = 0;

  read_buffer #(.DEPTH(DEPTH), .ADDR_STEP(ADDR_STEP), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .start                (start),
    .start_address        (start_address),
    .total_pixels         (total_pixels),
    .master_waitrequest   (master_waitrequest),
    .master_readdatavalid (master_readdatavalid),
    .master_readdata      (master_readdata),
    .master_read          (master_read),
    .master_address       (master_address),
    .pixel_out            (pixel_out),
    .pixel_valid          (pixel_valid),
    .pixel_ack            (pixel_ack),
    .busy                 (busy),
    .done_read            (done_read)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cycle++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  // Frame memory contents; the top byte is deliberately non-zero junk.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A00_C3A5;
  endfunction

  // Avalon slave: in-order responses with random waitstates and latency.
  initial forever begin
    int due;
    @(negedge clk);
    if (prev_stalled && (!master_read || master_address !== prev_addr)) stable_err++;
    if (resp_q.size() > 0 && resp_due[0] <= cycle) begin
      master_readdatavalid = 1'b1;
      master_readdata      = resp_q.pop_front();
      void'(resp_due.pop_front());
    end else begin
      master_readdatavalid = 1'b0;
      master_readdata      = $urandom;
    end
    if (master_read && stall_req == addr_log.size() && stall_cnt < stall_len) begin
      master_waitrequest = 1'b1;
      if (stall_cnt == 0) stall_addr = master_address;
      stall_cnt++;
    end else begin
      master_waitrequest = ($urandom_range(99) < wr_pct);
    end
    prev_stalled = master_read && master_waitrequest;
    prev_addr    = master_address;
    if (master_read) read_seen++;
    if (master_read && !master_waitrequest) begin
      addr_log.push_back(master_address);
      acc_cycle.push_back(cycle + 1);
      due = cycle + 1 + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      resp_q.push_back(mem_word(master_address));
      resp_due.push_back(due);
    end
  end

  // Consumer: random ack, optionally held low until ack_block_until.
  initial forever begin
    @(negedge clk);
    pixel_ack = (cycle >= ack_block_until) && ($urandom_range(99) < ack_pct);
    if (pixel_valid && first_valid < 0) first_valid = cycle;
    if (pixel_valid && pixel_ack) begin
      rx_q.push_back(pixel_out);
      ack_cycles.push_back(cycle);
    end
    if (done_read) begin
      done_count++;
      done_cycle = cycle;
    end
  end

  task automatic clear_monitors();
    addr_log.delete();
    acc_cycle.delete();
    rx_q.delete();
    ack_cycles.delete();
    first_valid = -1;
    done_count  = 0;
    done_cycle  = -1;
    stall_cnt   = 0;
    read_seen   = 0;
    stable_err  = 0;
  endtask

  task automatic start_frame(input logic [31:0] a, input int total);
    clear_monitors();
    @(negedge clk);
    start         = 1'b1;
    start_address = a;
    total_pixels  = CNT_W'(total);
    start_cycle   = cycle;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Frame scoreboard: address i must be a + i*ADDR_STEP, pixel i its low 24 bits.
  task automatic finish_frame(input logic [31:0] a, input int total, input int budget,
                              input string tag);
    int t;
    logic [31:0] ea, word;
    t = 0;
    while (done_count == 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_count != 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d expected 1 (waited %0d cycles)", tag, done_count, t);
    end
    n_checks++;
    if (rx_q.size() != total) begin
      n_fail++;
      $display("FAIL %s pixel_count: got %0d expected %0d", tag, rx_q.size(), total);
    end
    n_checks++;
    if (addr_log.size() != total) begin
      n_fail++;
      $display("FAIL %s read_count: got %0d expected %0d", tag, addr_log.size(), total);
    end
    for (int i = 0; i < total; i++) begin
      ea   = a + 32'(i * ADDR_STEP);
      word = mem_word(ea);
      if (i < addr_log.size()) begin
        n_checks++;
        if (addr_log[i] !== ea) begin
          n_fail++;
          $display("FAIL %s address[%0d]: got %h expected %h", tag, i, addr_log[i], ea);
        end
      end
      if (i < rx_q.size()) begin
        n_checks++;
        if (rx_q[i] !== word[23:0]) begin
          n_fail++;
          $display("FAIL %s pixel[%0d]: got %h expected %h", tag, i, rx_q[i], word[23:0]);
        end
      end
    end
    if (ack_cycles.size() > 0) begin
      n_checks++;
      if (done_cycle != ack_cycles[ack_cycles.size()-1] + 1) begin
        n_fail++;
        $display("FAIL %s done_timing: done at cycle %0d expected %0d", tag, done_cycle,
                 ack_cycles[ack_cycles.size()-1] + 1);
      end
    end
    n_checks++;
    if ({pixel_valid, busy, master_read} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s idle_after_done: valid/busy/read got %b expected 000", tag,
               {pixel_valid, busy, master_read});
    end
    n_checks++;
    if (stable_err != 0) begin
      n_fail++;
      $display("FAIL %s stall_stability: got %0d changes under waitrequest expected 0", tag, stable_err);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({master_read, master_address, pixel_out, pixel_valid, busy, done_read} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: read=%b addr=%h pix=%h valid=%b busy=%b done=%b expected all 0",
               master_read, master_address, pixel_out, pixel_valid, busy, done_read);
    end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({master_read, busy, pixel_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL post_reset_idle: read/busy/valid got %b expected 000",
               {master_read, busy, pixel_valid});
    end
  endtask

  task automatic test_basic();
    wr_pct = 0; lat_min = 0; lat_max = 0; ack_pct = 100; ack_block_until = 0;
    start_frame(32'h1000, 12);
    finish_frame(32'h1000, 12, 200, "basic12");
    n_checks++;
    if (first_valid - start_cycle < DEPTH + 2) begin
      n_fail++;
      $display("FAIL basic12 first_valid_latency: got %0d expected >= %0d",
               first_valid - start_cycle, DEPTH + 2);
    end
  endtask

  task automatic test_partial();
    wr_pct = 0; lat_min = 0; lat_max = 1; ack_pct = 100; ack_block_until = 0;
    start_frame(32'h1000, 8);
    finish_frame(32'h1000, 8, 200, "partial8");
  endtask

  task automatic test_waitrequest();
    wr_pct = 0; lat_min = 0; lat_max = 0; ack_pct = 100; ack_block_until = 0;
    stall_req = 2; stall_len = 3;
    start_frame(32'h1000, 12);
    finish_frame(32'h1000, 12, 200, "waitreq");
    n_checks++;
    if (stall_addr !== 32'h1008) begin
      n_fail++;
      $display("FAIL waitreq stall_address: got %h expected 00001008", stall_addr);
    end
    stall_req = -1; stall_len = 0;
  endtask

  task automatic test_backpressure();
    wr_pct = 0; lat_min = 0; lat_max = 0; ack_pct = 100; ack_block_until = 1 << 30;
    start_frame(32'h1000, 18);
    ack_block_until = start_cycle + 40;
    while (cycle < start_cycle + 39) @(negedge clk);
    n_checks++;
    if ({master_read, pixel_valid, busy} !== 3'b011 || addr_log.size() != 12) begin
      n_fail++;
      $display("FAIL backpressure stall_state: read/valid/busy got %b expected 011, reads got %0d expected 12",
               {master_read, pixel_valid, busy}, addr_log.size());
    end
    finish_frame(32'h1000, 18, 300, "backpressure");
    n_checks++;
    if (acc_cycle.size() < 13 || acc_cycle[12] <= start_cycle + 40) begin
      n_fail++;
      $display("FAIL backpressure resume: 13th read cycle got %0d expected > %0d",
               (acc_cycle.size() < 13) ? -1 : acc_cycle[12], start_cycle + 40);
    end
    n_checks++;
    if (ack_cycles.size() < 12 || ack_cycles[11] - ack_cycles[0] != 11) begin
      n_fail++;
      $display("FAIL backpressure throughput: 12 buffered pixels took %0d cycles expected 12",
               (ack_cycles.size() < 12) ? -1 : ack_cycles[11] - ack_cycles[0] + 1);
    end
    ack_block_until = 0;
  endtask

  task automatic test_zero();
    wr_pct = 0; lat_min = 0; lat_max = 0; ack_pct = 100; ack_block_until = 0;
    clear_monitors();
    @(negedge clk);
    start = 1'b1; start_address = 32'h1000; total_pixels = '0; start_cycle = cycle;
    @(negedge clk);
    n_checks++;
    if ({done_read, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL zero done_next_cycle: done/busy got %b expected 11", {done_read, busy});
    end
    start_address = 32'h5000; total_pixels = CNT_W'(5);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({done_read, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL zero done_single: done/busy got %b expected 00", {done_read, busy});
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (read_seen != 0 || done_count != 1 || done_cycle != start_cycle + 1) begin
      n_fail++;
      $display("FAIL zero ignored_start: reads got %0d expected 0, dones got %0d expected 1, done cycle got %0d expected %0d",
               read_seen, done_count, done_cycle, start_cycle + 1);
    end
  endtask

  task automatic test_reset_midframe();
    int t;
    wr_pct = 0; lat_min = 6; lat_max = 6; ack_pct = 100; ack_block_until = 0;
    start_frame(32'h2000, 12);
    t = 0;
    while (resp_q.size() < 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (resp_q.size() < 2) begin
      n_fail++;
      $display("FAIL midreset reads_issued: got %0d outstanding expected 2", resp_q.size());
    end
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    n_checks++;
    if ({master_read, master_address, pixel_out, pixel_valid, busy, done_read} !== '0) begin
      n_fail++;
      $display("FAIL midreset async_values: read=%b addr=%h pix=%h valid=%b busy=%b done=%b expected all 0",
               master_read, master_address, pixel_out, pixel_valid, busy, done_read);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    t = 0;
    while (resp_q.size() > 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({master_read, busy, pixel_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset late_response: read/busy/valid got %b expected 000",
               {master_read, busy, pixel_valid});
    end
    lat_min = 0; lat_max = 2;
    start_frame(32'h3000, 6);
    finish_frame(32'h3000, 6, 200, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int total;
    for (int f = 0; f < 6; f++) begin
      a       = (f == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      total   = (f == 0) ? 9 : $urandom_range(40, 1);
      wr_pct  = $urandom_range(50);
      lat_min = 0;
      lat_max = $urandom_range(4);
      ack_pct = $urandom_range(100, 30);
      ack_block_until = 0;
      start_frame(a, total);
      finish_frame(a, total, 200 + total * 30, (f == 0) ? "wrap" : "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_waitrequest();
    test_backpressure();
    test_zero();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/read_buffer.md
Name: read_buffer

Overview:
- Read-side counterpart of the pixel write path. Issues single-word Avalon-MM master reads from frame memory and captures the 24-bit pixel from each returned word.
- Holds pixels in two ping-pong banks of DEPTH entries each and hands them to the filter datapath one at a time with a valid/ack handshake.
- Memory fill of one bank overlaps consumer drain of the other bank.

Parameters:
DEPTH, 6, pixels per bank (1..15)
ADDR_STEP, 4, byte increment between consecutive pixel words
CNT_W, 20, width of the pixel-count port

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begin a frame read
start_address  input  32  byte address of first pixel word, latched on start
total_pixels  input  CNT_W  pixels to read, latched on start
master_waitrequest  input  1  Avalon slave stall
master_readdatavalid  input  1  read response valid
master_readdata  input  32  response word; pixel in [23:0], [31:24] ignored
master_read  output  1  Avalon read request
master_address  output  32  Avalon read address
pixel_out  output  24  current pixel to consumer
pixel_valid  output  1  pixel_out valid
pixel_ack  input  1  consumer takes pixel when pixel_valid & pixel_ack
busy  output  1  frame in progress
done_read  output  1  one-cycle pulse after last pixel accepted

Behaviour:
- Reset values: master_read=0, master_address=0, pixel_out=0, pixel_valid=0, busy=0, done_read=0. Both banks empty; all counters 0; FSM in IDLE. Reset mid-frame aborts the frame immediately; outstanding responses arriving after reset are ignored.
- Fill FSM states:
  - IDLE: on start, latch start_address and total_pixels and set busy=1. If total_pixels==0, pulse done_read on the next cycle, clear busy, and stay in IDLE. Otherwise go to ISSUE targeting bank 0.
  - ISSUE: master_read=1 and master_address=current address. A request is accepted on any cycle with master_waitrequest=0; on acceptance the address advances by ADDR_STEP and the issued count increments. master_read and master_address are held stable while master_waitrequest=1. After n accepted requests, where n = min(DEPTH, pixels remaining), drop master_read and go to WAIT.
  - WAIT: remain until n responses have landed in the fill bank, then mark the bank full. If pixels remain and the other bank is empty, go to ISSUE on the other bank; if pixels remain and the other bank is full, go to STALL; if no pixels remain, go to FINISH.
  - STALL: wait for the other bank to drain, then go to ISSUE.
  - FINISH: wait for all banks to drain, then pulse done_read and return to IDLE with busy=0.
- Responses:
  - Responses return in order. Each cycle with master_readdatavalid=1 writes master_readdata[23:0] to fill_bank[fill_idx] and increments fill_idx.
  - Responses may arrive while ISSUE is still active.
  - readdatavalid with zero outstanding requests is ignored.
- Drain side:
  - pixel_valid=1 whenever the drain bank is full. pixel_out = drain_bank[drain_idx], driven combinationally from the bank.
  - On pixel_valid & pixel_ack, drain_idx increments.
  - After the bank's n-th pixel is accepted, the bank is marked empty, drain_idx clears, and drain switches to the other bank. pixel_valid is 1 in the same cycle if that bank is already full.
  - Sustained throughput: 1 pixel/cycle while data is buffered.
- Latency: first pixel_valid is at least DEPTH+2 cycles after start with zero waitstates and zero response latency (one cycle for start, DEPTH issue cycles, one cycle to mark full).
- Partial last bank: when total_pixels is not a multiple of DEPTH, the last bank holds total_pixels mod DEPTH entries, and drain switches after that many.
- Simultaneous events:
  - Bank A becoming full in the same cycle bank B drains: both take effect; the fill FSM sees B empty that cycle.
  - A start pulse while busy=1 is ignored.
  - pixel_ack while pixel_valid=0 has no effect.
- Address arithmetic is 32-bit and wraps modulo 2^32.

Test Plan:
1. Zero waitstate/latency, start_address=0x1000, total_pixels=12, pixel_ack held 1:
   - master_address sequence 0x1000..0x102C, step 4.
   - 12 pixels out in order, readdata[31:24] stripped.
   - done_read is a single pulse one cycle after the 12th ack.
2. total_pixels=8:
   - Second bank issues exactly 2 reads (0x1018, 0x101C).
   - pixel_valid drops after 8 accepts; done_read pulses once.
3. master_waitrequest=1 for 3 cycles on the 3rd request:
   - master_read and master_address (0x1008) stay stable through the stall.
   - No address skipped or duplicated.
4. pixel_ack=0 for 40 cycles after start, total_pixels=18:
   - Both banks fill, FSM sits in STALL, master_read=0.
   - After ack is raised: 18 pixels in order, reads resume at 0x1030.
5. total_pixels=0:
   - done_read pulses next cycle; no master_read asserted.
   - A start issued while busy is ignored.
6. n_rst dropped mid-fill with 2 responses still outstanding:
   - All outputs go to reset values.
   - Late readdatavalid is ignored.
   - A subsequent start runs a clean 6-pixel frame.
